// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pkg
// Brief    : Shared sizes, op encodings, FSM state type and read-bus slice
//            helper for the register bank sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    localparam int NREG = 4;
    localparam int W    = 8;
    localparam int IDXW = 2;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_B = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    // Pick one register slice by index rather than OR-ing the whole bus.
    function automatic logic [W-1:0] bank_slice(input logic [NREG*W-1:0] bus,
                                                input logic [IDXW-1:0]   idx);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == IDXW'(i)) begin
                s = bus[i*W +: W];
            end
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_idx_dec.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_idx_dec
// Brief    : 2-to-4 one-hot index decoder with enable; all outputs 0 when
//            the enable is low.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_idx_dec
    import reg_bank_pkg::*;
(
    input  logic            en,
    input  logic [IDXW-1:0] idx,
    output logic [NREG-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_bit
            assign onehot[gi] = en && (idx == IDXW'(gi));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/reg_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_ctrl
// Brief    : Request/response sequencer driving the 4x8 register bank
//            (READ, WRITE, MOVE, SWAP). Define REG_BANK_CTRL_STATS_EN to
//            build the saturating completed-write counter.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_ctrl
    import reg_bank_pkg::*;
(
    input  logic                reg_clk,
    input  logic                reg_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [IDXW-1:0]     req_src,
    input  logic [IDXW-1:0]     req_dst,
    input  logic [W-1:0]        req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_data,
    output logic [NREG-1:0]     bank_rd_en,
    output logic [NREG-1:0]     bank_wr_en,
    output logic [W-1:0]        bank_wdata,
    input  logic [NREG*W-1:0]   bank_rdata,
    output logic [7:0]          stat_wr_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_op;
    logic [IDXW-1:0]    r_src;
    logic [IDXW-1:0]    r_dst;
    logic [W-1:0]       r_wdata;
    logic [W-1:0]       r_tmp_a;
    logic [W-1:0]       r_tmp_b;

    logic               w_accept;
    logic               w_rd_act;
    logic               w_wr_act;
    logic [IDXW-1:0]    w_rd_idx;
    logic [IDXW-1:0]    w_wr_idx;

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (req_op == OP_WRITE) ? ST_WR_A : ST_RD_A;
                end
            end
            ST_RD_A: begin
                if (r_op == OP_READ) begin
                    w_state_nxt = ST_RESP;
                end else if (r_op == OP_SWAP) begin
                    w_state_nxt = ST_RD_B;
                end else begin
                    w_state_nxt = ST_WR_A;
                end
            end
            ST_RD_B: w_state_nxt = ST_WR_A;
            ST_WR_A: w_state_nxt = (r_op == OP_SWAP) ? ST_WR_B : ST_RESP;
            ST_WR_B: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            r_op    <= OP_READ;
            r_src   <= '0;
            r_dst   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_op    <= req_op;
            r_src   <= req_src;
            r_dst   <= req_dst;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            r_tmp_a <= '0;
            r_tmp_b <= '0;
        end else begin
            if (r_state == ST_RD_A) begin
                r_tmp_a <= bank_slice(bank_rdata, r_src);
            end
            if (r_state == ST_RD_B) begin
                r_tmp_b <= bank_slice(bank_rdata, r_dst);
            end
        end
    end

    // Enables come straight from registered state, so an asynchronous
    // reset clears them in the same instant it clears the state.
    assign w_rd_act = (r_state == ST_RD_A) || (r_state == ST_RD_B);
    assign w_wr_act = (r_state == ST_WR_A) || (r_state == ST_WR_B);
    assign w_rd_idx = (r_state == ST_RD_B) ? r_dst : r_src;
    assign w_wr_idx = (r_state == ST_WR_B) ? r_src : r_dst;

    reg_bank_idx_dec u_rd_dec (
        .en     (w_rd_act),
        .idx    (w_rd_idx),
        .onehot (bank_rd_en)
    );

    reg_bank_idx_dec u_wr_dec (
        .en     (w_wr_act),
        .idx    (w_wr_idx),
        .onehot (bank_wr_en)
    );

    always_comb begin
        bank_wdata = '0;
        if (r_state == ST_WR_A) begin
            bank_wdata = (r_op == OP_WRITE) ? r_wdata : r_tmp_a;
        end else if (r_state == ST_WR_B) begin
            bank_wdata = r_tmp_b;
        end
    end

    // Response sources are all frozen while in RESP, so data holds stable.
    always_comb begin
        rsp_data = '0;
        if (r_state == ST_RESP) begin
            case (r_op)
                OP_WRITE: rsp_data = r_wdata;
                OP_SWAP:  rsp_data = r_tmp_b;
                default:  rsp_data = r_tmp_a;
            endcase
        end
    end

`ifdef REG_BANK_CTRL_STATS_EN
    logic [7:0] r_wr_cnt;

    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            r_wr_cnt <= '0;
        end else if (w_wr_act && (r_wr_cnt != 8'hFF)) begin
            r_wr_cnt <= r_wr_cnt + 8'd1;
        end
    end

    assign stat_wr_cnt = r_wr_cnt;
`else
    assign stat_wr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_ctrl
// Brief    : Scoreboard bench for reg_bank_ctrl with a behavioural 4x8 bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_ctrl;

    logic        reg_clk = 1'b0;
    logic        reg_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [1:0]  req_src = 2'b00;
    logic [1:0]  req_dst = 2'b00;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_data;
    logic [3:0]  bank_rd_en;
    logic [3:0]  bank_wr_en;
    logic [7:0]  bank_wdata;
    logic [31:0] bank_rdata;
    logic [7:0]  stat_wr_cnt;

    reg_bank_ctrl dut (
        .reg_clk     (reg_clk),
        .reg_rst     (reg_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .bank_rd_en  (bank_rd_en),
        .bank_wr_en  (bank_wr_en),
        .bank_wdata  (bank_wdata),
        .bank_rdata  (bank_rdata),
        .stat_wr_cnt (stat_wr_cnt)
    );

    always #5 reg_clk = ~reg_clk;

    // Behavioural register bank sharing the controller reset
    logic [7:0] bank [4];
    always @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++) if (bank_wr_en[i]) bank[i] <= bank_wdata;
        end
    end
    always @* begin
        bank_rdata = '0;
        for (int i = 0; i < 4; i++) if (bank_rd_en[i]) bank_rdata[i*8 +: 8] = bank[i];
    end

    int cyc = 0;
    always @(posedge reg_clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] data; int due; } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cnt_wr2 = 0;

    localparam logic [1:0] RD = 2'b00, WR = 2'b01, MV = 2'b10, SW = 2'b11;
`ifdef REG_BANK_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [7:0] wd, input logic [7:0] exp, input int lat);
        int n;
        exp_t e;
        @(negedge reg_clk);
        req_op = op; req_src = src; req_dst = dst; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge reg_clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        e.data = exp;
        e.due  = cyc + lat;
        q.push_back(e);
        @(posedge reg_clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !req_ready) && n < 100) begin
            @(negedge reg_clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 0, 1);
    endtask

    // Monitor: latency on response rise, data on handshake, enable invariants
    initial begin
        logic v_prev;
        exp_t e;
        v_prev = 1'b0;
        forever begin
            @(negedge reg_clk);
            if (reg_rst) begin
                v_prev = 1'b0;
                continue;
            end
            if (bank_wr_en == 4'b0100) cnt_wr2++;
            check("rd_en_onehot0", 32'($onehot0(bank_rd_en)), 1);
            check("wr_en_onehot0", 32'($onehot0(bank_wr_en)), 1);
            check("rd_wr_exclusive", 32'((|bank_rd_en) && (|bank_wr_en)), 0);
            if (rsp_valid && !v_prev) begin
                if (q.size() == 0) check("unexpected_rsp", 1, 0);
                else check("rsp_latency_cycle", 32'(cyc), 32'(q[0].due));
            end
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                e = q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
            v_prev = rsp_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge reg_clk);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rd_en", 32'(bank_rd_en), 0);
        check("rst_wr_en", 32'(bank_wr_en), 0);
        check("rst_wdata", 32'(bank_wdata), 0);
        check("rst_stat", 32'(stat_wr_cnt), 0);
        reg_rst = 1'b0;

        // WRITE then READ back r2
        issue(WR, 2'd0, 2'd2, 8'hA5, 8'hA5, 2);
        issue(RD, 2'd2, 2'd0, 8'h00, 8'hA5, 2);
        wait_idle();
        check("wr_en_0100_cycles", 32'(cnt_wr2), 1);

        // MOVE r3 -> r0
        issue(WR, 2'd0, 2'd0, 8'h11, 8'h11, 2);
        issue(WR, 2'd0, 2'd3, 8'h3C, 8'h3C, 2);
        issue(MV, 2'd3, 2'd0, 8'h00, 8'h3C, 3);
        issue(RD, 2'd0, 2'd0, 8'h00, 8'h3C, 2);
        issue(RD, 2'd3, 2'd0, 8'h00, 8'h3C, 2);

        // SWAP r1 <-> r2
        issue(WR, 2'd0, 2'd1, 8'h12, 8'h12, 2);
        issue(WR, 2'd0, 2'd2, 8'h34, 8'h34, 2);
        issue(SW, 2'd1, 2'd2, 8'h00, 8'h34, 5);
        issue(RD, 2'd1, 2'd0, 8'h00, 8'h34, 2);
        issue(RD, 2'd2, 2'd0, 8'h00, 8'h12, 2);
        wait_idle();
        check("stat_after_swap", 32'(stat_wr_cnt), STATS ? 32'd8 : 32'd0);

        // Response back-pressure
        rsp_ready = 1'b0;
        issue(RD, 2'd0, 2'd0, 8'h00, 8'h3C, 2);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge reg_clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 1);
            check("stall_rsp_data", 32'(rsp_data), 32'h3C);
            check("stall_req_ready", 32'(req_ready), 0);
            @(negedge reg_clk);
        end
        @(posedge reg_clk);
        #1 rsp_ready = 1'b1;
        issue(RD, 2'd3, 2'd0, 8'h00, 8'h3C, 2);
        wait_idle();

        // Reset during WR_A of a SWAP
        issue(SW, 2'd0, 2'd3, 8'h00, 8'h3C, 5);
        n = 0;
        while (bank_wr_en == 4'b0000 && n < 20) begin
            @(negedge reg_clk);
            n++;
        end
        check("swap_reached_wr_a", 32'(bank_wr_en), 32'b0001 << 3);
        #1 reg_rst = 1'b1;
        q.delete();
        #1;
        check("rst_mid_rd_en", 32'(bank_rd_en), 0);
        check("rst_mid_wr_en", 32'(bank_wr_en), 0);
        @(posedge reg_clk);
        @(posedge reg_clk);
        @(negedge reg_clk);
        reg_rst = 1'b0;
        @(negedge reg_clk);
        check("post_rst_req_ready", 32'(req_ready), 1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 0);
        check("post_rst_stat", 32'(stat_wr_cnt), 0);
        for (int i = 0; i < 4; i++) issue(RD, 2'(i), 2'd0, 8'h00, 8'h00, 2);
        wait_idle();

        // src == dst SWAP and counter saturation
        issue(WR, 2'd0, 2'd3, 8'h5A, 8'h5A, 2);
        wait_idle();
        check("stat_one_write", 32'(stat_wr_cnt), STATS ? 32'd1 : 32'd0);
        for (int i = 0; i < 130; i++) issue(SW, 2'd3, 2'd3, 8'h00, 8'h5A, 5);
        issue(RD, 2'd3, 2'd0, 8'h00, 8'h5A, 2);
        wait_idle();
        check("stat_saturated", 32'(stat_wr_cnt), STATS ? 32'd255 : 32'd0);

        repeat (2) @(negedge reg_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
